// File: rtl/seq_div.sv
// Radix-2 restoring divider: quot/rem of two m-bit operands, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands (truncating toward zero).
module seq_div #(
  parameter int unsigned m = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [m-1:0] a,
  input  logic [m-1:0] b,
  output logic [m-1:0] quot,
  output logic [m-1:0] rem,
  output logic         done,
  output logic         busy,
  output logic         dbz
);
  localparam int unsigned CW = $clog2(m) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t        state;
  // The top bit of the partial remainder is always zero between iterations,
  // so only its low m bits are stored; the m+1-bit trial value is formed below.
  logic [m-1:0]  r;
  logic [m-1:0]  q;
  logic [m-1:0]  dvsr;
  logic [m-1:0]  dvnd;
  logic [CW-1:0] count;
  logic          zero;
  logic [m:0]    diff;
  logic [m-1:0]  mag_a;
  logic [m-1:0]  mag_b;
  logic [m-1:0]  res_q;
  logic [m-1:0]  res_r;

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  always_comb begin
    mag_a = a[m-1] ? -a : a;
    mag_b = b[m-1] ? -b : b;
    res_q = neg_q ? -q : q;
    res_r = neg_r ? -r : r;
  end
`else
  always_comb begin
    mag_a = a;
    mag_b = b;
    res_q = q;
    res_r = r;
  end
`endif

  always_comb begin
    diff = {r, q[m-1]} - {1'b0, dvsr};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      r     <= '0;
      q     <= '0;
      dvsr  <= '0;
      dvnd  <= '0;
      count <= '0;
      zero  <= 1'b0;
      quot  <= '0;
      rem   <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
      dbz   <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            r     <= '0;
            q     <= mag_a;
            dvsr  <= mag_b;
            dvnd  <= a;
            count <= '0;
            zero  <= (b == '0);
            busy  <= 1'b1;
            state <= CALC;
`ifdef DIV_SIGNED_EN
            neg_q <= a[m-1] ^ b[m-1];
            neg_r <= a[m-1];
`endif
          end
        end
        CALC: begin
          if (!diff[m]) begin
            r <= diff[m-1:0];
            q <= {q[m-2:0], 1'b1};
          end else begin
            r <= {r[m-2:0], q[m-1]};
            q <= {q[m-2:0], 1'b0};
          end
          count <= count + CW'(1);
          if (count == CW'(m - 1)) state <= FIN;
        end
        FIN: begin
          quot  <= zero ? '1 : res_q;
          rem   <= zero ? dvnd : res_r;
          dbz   <= zero;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_div.sv
// Directed bench for seq_div: an arithmetic latency/result model checked every cycle,
// plus hand-computed expectations for each directed vector.
module tb_seq_div;
  localparam int unsigned M = 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [M-1:0] a = '0;
  logic [M-1:0] b = '0;
  logic [M-1:0] quot;
  logic [M-1:0] rem;
  logic         done;
  logic         busy;
  logic         dbz;

  int vectors = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_div #(.m(M)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .quot(quot), .rem(rem), .done(done), .busy(busy), .dbz(dbz)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: an accepted request finishes M+1 edges later with plain arithmetic results.
  int unsigned  left = 0;
  bit           model_live = 0;
  logic         m_busy, m_done, m_dbz;
  logic [M-1:0] m_q, m_r, ca, cb;
  int           sa, sb;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (!rst_n) begin
      left = 0; m_busy = 1'b0; m_q = '0; m_r = '0; m_dbz = 1'b0;
      model_live = 1;
    end else if (left == 0) begin
      if (start) begin
        ca = a; cb = b; left = M + 1; m_busy = 1'b1;
      end
    end else begin
      left--;
      if (left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_dbz  = (cb == 0);
        if (cb == 0) begin
          m_q = '1;
          m_r = ca;
        end else begin
`ifdef DIV_SIGNED_EN
          sa = int'($signed(ca));
          sb = int'($signed(cb));
          m_q = M'(sa / sb);
          m_r = M'(sa % sb);
`else
          sa = int'(ca);
          sb = int'(cb);
          m_q = M'(sa / sb);
          m_r = M'(sa % sb);
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("quot", 32'(quot), 32'(m_q));
      chk("rem",  32'(rem),  32'(m_r));
      chk("dbz",  32'(dbz),  32'(m_dbz));
    end
  end

  // Called at a negedge with the divider idle; returns in the done cycle.
  task automatic run(input logic [M-1:0] x, input logic [M-1:0] y,
                     input logic [M-1:0] eq, input logic [M-1:0] er,
                     input logic ed, input string tag);
    int cyc;
    int busy_low;
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    busy_low = 0;
    while (!done && cyc < 40) begin
      if (!busy) busy_low++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"},  32'(cyc - 1), 32'd13);
    chk({tag, "_busy_run"}, 32'(busy_low), 32'd0);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_quot"}, 32'(quot), 32'(eq));
    chk({tag, "_rem"},  32'(rem),  32'(er));
    chk({tag, "_dbz"},  32'(dbz),  32'(ed));
  endtask

  initial begin
    int ndone;
    repeat (3) @(negedge clk);
    chk("rst_quot", 32'(quot), 32'd0);
    chk("rst_rem",  32'(rem),  32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dbz",  32'(dbz),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run(12'd100, 12'd7, 12'd14, 12'd2, 1'b0, "d100_7");
`ifdef DIV_SIGNED_EN
    run(12'd4095, 12'd1, 12'hFFF, 12'd0, 1'b0, "dm1_1");
    run(12'd5, 12'd4095, 12'hFFB, 12'd0, 1'b0, "d5_m1");
`else
    run(12'd4095, 12'd1, 12'd4095, 12'd0, 1'b0, "d4095_1");
    run(12'd5, 12'd4095, 12'd0, 12'd5, 1'b0, "d5_4095");
`endif
    run(12'd55, 12'd0, 12'd4095, 12'd55, 1'b1, "d55_0");
    run(12'd9, 12'd3, 12'd3, 12'd0, 1'b0, "d9_3");

    // start held high: accepts at edges 0,14,28,42,56 -> five done pulses by cycle 70
    ndone = 0;
    a = 12'd1234; b = 12'd17; start = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      if (done) ndone++;
      a = M'(37 * i + 11);
      b = M'((i % 5) * 301 + 3);
      if (i == 70) start = 1'b0;
    end
    chk("stream_done_count", 32'(ndone), 32'd5);
    @(negedge clk);

    a = 12'd3000; b = 12'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quot", 32'(quot), 32'd0);
    chk("abort_rem",  32'(rem),  32'd0);
    rst_n = 1'b1;
    ndone = 0;
    repeat (16) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run(12'd200, 12'd9, 12'd22, 12'd2, 1'b0, "d200_9");

`ifdef DIV_SIGNED_EN
    run(12'hF9C, 12'd7, 12'hFF2, 12'hFFE, 1'b0, "dm100_7");
    run(12'h800, 12'hFFF, 12'h800, 12'd0, 1'b0, "dmin_m1");
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
